seven_seg_scan_driver: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 68 ++++++
 rtl/seven_seg_scan_driver_bin2bcd_seq.sv | 106 ++++++++++
 rtl/seven_seg_scan_driver.sv | 184 ++++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the elevator floor-indicator display driver:
// segment glyphs ({dp,g,f,e,d,c,b,a}, active-high), the converter state
// encoding, and small helpers for glyph lookup and BCD sizing.
package seven_seg_pkg;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DASH  = 8'h40;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } conv_state_e;

    // Non-decimal nibbles never occur on a valid BCD path; show them blank.
    function automatic logic [7:0] nibble_to_seg(input logic [3:0] nib);
        logic [7:0] glyph;
        case (nib)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_BLANK;
        endcase
        return glyph;
    endfunction

    // Decimal digits needed to hold the largest value of a 'width'-bit number.
    function automatic int bcd_digits_for(input int width);
        longint maxv;
        int     n;
        maxv = (64'sd1 <<< width) - 64'sd1;
        n    = 1;
        for (int i = 0; i < 20; i++) begin
            if (maxv >= 64'sd10) begin
                maxv = maxv / 64'sd10;
                n    = n + 1;
            end
        end
        return n;
    endfunction

    function automatic longint pow10(input int n);
        longint p;
        p = 64'sd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'sd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/seven_seg_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// Ports: clk, rst_n (sync, active-low), start_i (load bin_i and convert),
//        bin_i (binary value), busy_o (conversion in flight, including the
//        result-valid cycle), done_o (one-cycle pulse, bcd_o valid),
//        bcd_o (NUM_DIGITS BCD nibbles, least-significant digit in [3:0]).
module bin2bcd_seq
    import seven_seg_pkg::*;
#(
    parameter int BIN_W      = 4,
    parameter int NUM_DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [BIN_W-1:0]        bin_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [NUM_DIGITS*4-1:0] bcd_o
);

    // The shift register always holds enough digits for the full input
    // range, so overflow beyond NUM_DIGITS is judged by the caller.
    localparam int NEED_DIGITS = bcd_digits_for(BIN_W);
    localparam int CONV_DIGITS = (NEED_DIGITS > NUM_DIGITS) ? NEED_DIGITS : NUM_DIGITS;
    localparam int BCD_W       = CONV_DIGITS * 4;
    localparam int SR_W        = BCD_W + BIN_W;
    localparam int CNT_W       = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    conv_state_e             state_q, state_d;
    logic [SR_W-1:0]         sr_q, sr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_DIGITS*4-1:0] bcd_q, bcd_d;
    logic                    done_q, done_d;

    // One double-dabble step: correct every BCD nibble >= 5, then shift left.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        for (int k = 0; k < CONV_DIGITS; k++) begin
            if (t[BIN_W+4*k +: 4] >= 4'd5) begin
                t[BIN_W+4*k +: 4] = t[BIN_W+4*k +: 4] + 4'd3;
            end
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    // Converter next-state: load, BIN_W shift steps, then latch the result.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    sr_d    = {{BCD_W{1'b0}}, bin_i};
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                sr_d = dabble_step(sr_q);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                bcd_d   = sr_q[BIN_W +: NUM_DIGITS*4];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Converter state registers; reset abandons any conversion in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    // Busy stays high through the result-valid cycle so no new start can
    // race the display update.
    assign busy_o = (state_q != IDLE) || done_q;
    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment floor indicator.
// Ports: clk, rst_n (sync, active-low), floor (binary floor number),
//        moving (lights DP on the most-significant digit), blink (flash),
//        busy (BCD conversion in progress), seg ({dp,g,f,e,d,c,b,a},
//        registered), an (one-hot digit enable, registered).
// A floor change is converted to BCD in the background; the display scans
// one digit per REFRESH_DIV cycles with leading-zero blanking and blink.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int FLOOR_W     = 4,
    parameter int NUM_DIGITS  = 2,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_TICKS = 64,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FLOOR_W-1:0]    floor,
    input  logic                  moving,
    input  logic                  blink,
    output logic                  busy,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int          PRESC_W   = $clog2(REFRESH_DIV);
    localparam int          DIG_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int          BCNT_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [63:0] OVF_LIMIT = 64'(pow10(NUM_DIGITS));

    logic [FLOOR_W-1:0]      last_floor_q, last_floor_d;
    logic [NUM_DIGITS*4-1:0] disp_q, disp_d;
    logic                    ovf_q, ovf_d;
    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [DIG_W-1:0]        digit_q, digit_d;
    logic [BCNT_W-1:0]       bcnt_q, bcnt_d;
    logic                    phase_on_q, phase_on_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    start_s, conv_busy_s, conv_done_s, tick_s;
    logic [NUM_DIGITS*4-1:0] conv_bcd_s;
    logic [3:0]              nib_s;
    logic                    lead_blank_s;
    logic [7:0]              glyph_s, seg_pre_s;
    logic [NUM_DIGITS-1:0]   an_pre_s;

    // Changes arriving while a conversion runs are left for IDLE to re-detect.
    assign start_s = (floor != last_floor_q) && !conv_busy_s;
    assign tick_s  = (presc_q == PRESC_W'(REFRESH_DIV - 1));

    bin2bcd_seq #(
        .BIN_W      (FLOOR_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_s),
        .bin_i   (floor),
        .busy_o  (conv_busy_s),
        .done_o  (conv_done_s),
        .bcd_o   (conv_bcd_s)
    );

    // Change capture and display-register update on conversion completion.
    always_comb begin
        last_floor_d = last_floor_q;
        disp_d       = disp_q;
        ovf_d        = ovf_q;
        if (start_s) begin
            last_floor_d = floor;
        end else begin
            last_floor_d = last_floor_q;
        end
        if (conv_done_s) begin
            // last_floor_q is frozen while busy, so it is the converted value.
            disp_d = conv_bcd_s;
            ovf_d  = (64'(last_floor_q) >= OVF_LIMIT);
        end else begin
            disp_d = disp_q;
            ovf_d  = ovf_q;
        end
    end

    // Refresh prescaler, digit index and blink phase.
    always_comb begin
        presc_d    = presc_q + 1'b1;
        digit_d    = digit_q;
        bcnt_d     = bcnt_q;
        phase_on_d = phase_on_q;
        if (tick_s) begin
            presc_d = '0;
            if (digit_q == DIG_W'(NUM_DIGITS - 1)) begin
                digit_d = '0;
            end else begin
                digit_d = digit_q + 1'b1;
            end
        end else begin
            digit_d = digit_q;
        end
        if (!blink) begin
            bcnt_d     = '0;
            phase_on_d = 1'b1;
        end else if (tick_s) begin
            if (bcnt_q == BCNT_W'(BLINK_TICKS - 1)) begin
                bcnt_d     = '0;
                phase_on_d = ~phase_on_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end else begin
            bcnt_d = bcnt_q;
        end
    end

    // Glyph for the current digit: dash on overflow, leading-zero blanking,
    // DP on the top digit, and blink-off forcing everything dark.
    always_comb begin
        nib_s        = disp_q[4*int'(digit_q) +: 4];
        lead_blank_s = (digit_q != '0);
        for (int j = 0; j < NUM_DIGITS; j++) begin
            lead_blank_s = lead_blank_s &
                           ~((DIG_W'(j) >= digit_q) && (disp_q[4*j +: 4] != 4'd0));
        end
        if (ovf_q) begin
            glyph_s = SEG_DASH;
        end else if (lead_blank_s) begin
            glyph_s = SEG_BLANK;
        end else begin
            glyph_s = nibble_to_seg(nib_s);
        end
        seg_pre_s = {moving && (digit_q == DIG_W'(NUM_DIGITS - 1)), glyph_s[6:0]};
        an_pre_s  = '0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            an_pre_s[j] = (DIG_W'(j) == digit_q);
        end
        // Live blink input here so dropping blink restores output next clk.
        if (blink && !phase_on_q) begin
            seg_pre_s = SEG_BLANK;
            an_pre_s  = '0;
        end else begin
            seg_pre_s = seg_pre_s;
            an_pre_s  = an_pre_s;
        end
        if (ACTIVE_LOW != 0) begin
            seg_d = ~seg_pre_s;
            an_d  = ~an_pre_s;
        end else begin
            seg_d = seg_pre_s;
            an_d  = an_pre_s;
        end
    end

    // Top-level state and registered pin drivers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_floor_q <= '0;
            disp_q       <= '0;
            ovf_q        <= 1'b0;
            presc_q      <= '0;
            digit_q      <= '0;
            bcnt_q       <= '0;
            phase_on_q   <= 1'b1;
            seg_q        <= (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
            an_q         <= (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
        end else begin
            last_floor_q <= last_floor_d;
            disp_q       <= disp_d;
            ovf_q        <= ovf_d;
            presc_q      <= presc_d;
            digit_q      <= digit_d;
            bcnt_q       <= bcnt_d;
            phase_on_q   <= phase_on_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = conv_busy_s;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;

    localparam int FW = 4;
    localparam int ND = 2;
    localparam int RD = 4;
    localparam int BT = 2;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic [FW-1:0] floor  = '0;
    logic          moving = 1'b0;
    logic          blink  = 1'b0;
    logic          busy;
    logic [7:0]    seg;
    logic [ND-1:0] an;

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed-cycle arithmetic, not a copy of the RTL.
    int         m_cyc, m_last, m_pend, m_shown, m_cnt, m_bticks;
    bit         m_busy;
    logic [7:0] exp_seg;
    logic [ND-1:0] exp_an;
    logic       exp_busy;
    logic [7:0] glyphs [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    seven_seg_scan_driver #(
        .FLOOR_W     (FW),
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLINK_TICKS (BT),
        .ACTIVE_LOW  (0)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .floor  (floor),
        .moving (moving),
        .blink  (blink),
        .busy   (busy),
        .seg    (seg),
        .an     (an)
    );

    always #5 clk = ~clk;

    // What the pins should show after this rising edge, given the inputs now.
    task automatic model_edge();
        int  dig, p10, lim;
        bit  off;
        if (!rst_n) begin
            m_cyc = 0; m_last = 0; m_pend = 0; m_shown = 0; m_cnt = 0;
            m_bticks = 0; m_busy = 0;
            exp_seg = 8'h00; exp_an = '0;
        end else begin
            dig = (m_cyc / RD) % ND;
            p10 = 1;
            for (int k = 0; k < dig; k++) p10 = p10 * 10;
            lim = 1;
            for (int k = 0; k < ND; k++) lim = lim * 10;
            off = blink && (((m_bticks / BT) % 2) == 1);
            if (off) begin
                exp_seg = 8'h00;
                exp_an  = '0;
            end else begin
                exp_an = ND'(1 << dig);
                if (m_shown >= lim) exp_seg = 8'h40;
                else if (dig > 0 && (m_shown / p10) == 0) exp_seg = 8'h00;
                else exp_seg = glyphs[(m_shown / p10) % 10];
                if (moving && dig == ND - 1) exp_seg[7] = 1'b1;
            end
            if (blink) begin
                if ((m_cyc % RD) == RD - 1) m_bticks++;
            end else begin
                m_bticks = 0;
            end
            m_cyc++;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_shown = m_pend;
                    m_busy  = 0;
                end
            end else if (int'(floor) != m_last) begin
                m_last = int'(floor);
                m_pend = int'(floor);
                m_busy = 1;
                m_cnt  = FW + 2;
            end
        end
        exp_busy = m_busy;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            step();
            checks++;
            if ({seg, an, busy} !== {8'h00, 2'b00, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold seg=%h an=%b busy=%b expected seg=00 an=00 busy=0", seg, an, busy);
            end
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({seg, an} !== {8'h3F, 2'b01}) begin
            errors++;
            $display("FAIL reset_first_digit seg=%h an=%b expected seg=3f an=01", seg, an);
        end
        repeat (16) begin
            step();
            checks++;
            if ({seg, an, busy} !== {exp_seg, exp_an, exp_busy}) begin
                errors++;
                $display("FAIL reset_scan cyc=%0d seg=%h an=%b busy=%b expected seg=%h an=%b busy=%b",
                         m_cyc, seg, an, busy, exp_seg, exp_an, exp_busy);
            end
        end
    endtask

    task automatic test_convert();
        int busy_cycles;
        busy_cycles = 0;
        floor = 4'd12;
        repeat (24) begin
            step();
            busy_cycles += int'(busy);
            checks++;
            if ({seg, an, busy} !== {exp_seg, exp_an, exp_busy}) begin
                errors++;
                $display("FAIL convert12 cyc=%0d seg=%h an=%b busy=%b expected seg=%h an=%b busy=%b",
                         m_cyc, seg, an, busy, exp_seg, exp_an, exp_busy);
            end
        end
        checks++;
        if (busy_cycles !== FW + 2) begin
            errors++;
            $display("FAIL convert12_busy_len got %0d cycles expected %0d", busy_cycles, FW + 2);
        end
    endtask

    task automatic test_busy_ignore();
        floor = 4'd3;
        repeat (10) step();
        floor = 4'd9;
        repeat (2) step();
        floor = 4'd7;
        repeat (30) begin
            step();
            checks++;
            if ({seg, an, busy} !== {exp_seg, exp_an, exp_busy}) begin
                errors++;
                $display("FAIL busy_ignore cyc=%0d seg=%h an=%b busy=%b expected seg=%h an=%b busy=%b",
                         m_cyc, seg, an, busy, exp_seg, exp_an, exp_busy);
            end
        end
    endtask

    task automatic test_moving();
        floor = 4'd5;
        repeat (12) step();
        moving = 1'b1;
        repeat (10) begin
            step();
            checks++;
            if ({seg, an, busy} !== {exp_seg, exp_an, exp_busy}) begin
                errors++;
                $display("FAIL moving_dp cyc=%0d seg=%h an=%b busy=%b expected seg=%h an=%b busy=%b",
                         m_cyc, seg, an, busy, exp_seg, exp_an, exp_busy);
            end
        end
        moving = 1'b0;
        repeat (8) begin
            step();
            checks++;
            if ({seg, an, busy} !== {exp_seg, exp_an, exp_busy}) begin
                errors++;
                $display("FAIL moving_clear cyc=%0d seg=%h an=%b busy=%b expected seg=%h an=%b busy=%b",
                         m_cyc, seg, an, busy, exp_seg, exp_an, exp_busy);
            end
        end
    endtask

    task automatic test_blink();
        int guard;
        blink = 1'b1;
        repeat (36) begin
            step();
            checks++;
            if ({seg, an, busy} !== {exp_seg, exp_an, exp_busy}) begin
                errors++;
                $display("FAIL blink_run cyc=%0d seg=%h an=%b busy=%b expected seg=%h an=%b busy=%b",
                         m_cyc, seg, an, busy, exp_seg, exp_an, exp_busy);
            end
        end
        // Move into an off phase, then drop blink there.
        guard = 0;
        while (exp_an != '0 && guard < 40) begin
            step();
            guard++;
        end
        checks++;
        if (exp_an != '0 || an !== 2'b00) begin
            errors++;
            $display("FAIL blink_off_reached an=%b expected an=00", an);
        end
        step();
        blink = 1'b0;
        step();
        checks++;
        if (an === 2'b00 || {seg, an} !== {exp_seg, exp_an}) begin
            errors++;
            $display("FAIL blink_release seg=%h an=%b expected seg=%h an=%b", seg, an, exp_seg, exp_an);
        end
    endtask

    task automatic test_reset_mid_conv();
        floor = 4'd15;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        checks++;
        if ({busy, seg, an} !== {1'b0, 8'h00, 2'b00}) begin
            errors++;
            $display("FAIL reset_mid_conv busy=%b seg=%h an=%b expected busy=0 seg=00 an=00", busy, seg, an);
        end
        rst_n = 1'b1;
        repeat (24) begin
            step();
            checks++;
            if ({seg, an, busy} !== {exp_seg, exp_an, exp_busy}) begin
                errors++;
                $display("FAIL reset_mid_recover cyc=%0d seg=%h an=%b busy=%b expected seg=%h an=%b busy=%b",
                         m_cyc, seg, an, busy, exp_seg, exp_an, exp_busy);
            end
        end
    endtask

    task automatic test_random();
        repeat (1500) begin
            if ($urandom_range(0, 7) == 0) floor = FW'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) moving = ~moving;
            if ($urandom_range(0, 39) == 0) blink = ~blink;
            rst_n = ($urandom_range(0, 299) != 0);
            step();
            checks++;
            if ({seg, an, busy} !== {exp_seg, exp_an, exp_busy}) begin
                errors++;
                $display("FAIL random cyc=%0d seg=%h an=%b busy=%b expected seg=%h an=%b busy=%b",
                         m_cyc, seg, an, busy, exp_seg, exp_an, exp_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_busy_ignore();
        test_moving();
        test_blink();
        test_reset_mid_conv();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
